fsm_in_cond: RTL and testbench
==============================

# fsm_in_cond

Input conditioner that sits directly upstream of the micro-programmed FSM and drives its `A`/`B` inputs. It synchronises asynchronous raw inputs into the `CLK` domain, debounces each bit independently, and publishes clean, glitch-free levels plus a one-cycle change strobe. The FSM's test bench and top level connect `D_OUT[0]` to `A` and `D_OUT[1]` to `B`.

## Interface
- `W`, 2: number of conditioned bits.
- `DB`, 4: debounce length in cycles, minimum 1; a bit must disagree with its output for `DB` consecutive synchronised samples before the output flips.
- `RST_VAL`, `{W{1'b0}}`: reset value of the synchroniser flops and of `D_OUT`.
- `CLK`  in  1  single clock; all flops rise-edge triggered.
- `CLR`  in  1  reset, asynchronous, active-low; every flop is cleared while `CLR`=0.
- `D_IN`  in  W  raw asynchronous inputs.
- `D_OUT`  out  W  conditioned levels.
- `CHG`  out  1  one-cycle pulse; 1 in the cycle `D_OUT` changes.
- `RISE`, `FALL`  out  W each  present only with `INCOND_EDGE_EN`.

## Operation
- Per bit: two-flop synchroniser `s1`→`s2`, one debounce counter `cnt` of width `max(1,$clog2(DB))`, and a two-state FSM.
  - `IDLE`: `s2 == D_OUT[i]`, and `cnt` is held at 0.
  - `COUNT`: `s2 != D_OUT[i]`.
- Transitions and actions, evaluated at each rising edge:
  - `IDLE`→`COUNT` when `s2 != D_OUT[i]`. If `DB`=1, `D_OUT[i]` flips at this same edge and the bit stays in `IDLE`.
  - In `COUNT`, when `s2 != D_OUT[i]` and `cnt < DB-1`: `cnt` increments.
  - In `COUNT`, when `s2 != D_OUT[i]` and `cnt == DB-1`: `D_OUT[i]` takes `s2`, `cnt` returns to 0, and the bit goes to `IDLE`.
  - In `COUNT`, when `s2 == D_OUT[i]` (bounce): `cnt` returns to 0, the bit goes to `IDLE`, and `D_OUT` is unchanged.
- `CHG` is registered and equals the OR of the per-bit flip conditions at that edge. It is high for exactly one cycle per flip event, including when several bits flip at the same edge.
- Bits are fully independent; simultaneous flips on several bits produce one `CHG` cycle.
- Reset values (`CLR`=0, asynchronous):
  - `s1`, `s2`, `D_OUT` = `RST_VAL`.
  - `cnt` = 0, state = `IDLE`.
  - `CHG` = 0; `RISE` and `FALL` = 0.
- Reset release does not produce a spurious `CHG`.
- Reset asserted mid-count abandons the count. After release, counting restarts from 0.

## Timing
- Raw input changes and stays stable; first sampled at edge k:
  - `s1` updates at k and `s2` at k+1.
  - `D_OUT` and `CHG` update at edge k+DB+1 and are visible in the cycle after it.
  - Total latency is DB+1 edges: 5 at default, 2 for `DB`=1.
- A bounce that lasts fewer than DB synchronised cycles never reaches `D_OUT`.
- `CHG` deasserts at the next edge unless another flip occurs at that edge.
- Outputs are glitch-free: every output is a flop output with no combinational path from `D_IN`.

## Configuration
- `INCOND_EDGE_EN` defined:
  - Adds ports `RISE[W-1:0]` and `FALL[W-1:0]`, both registered.
  - `RISE[i]` pulses for one cycle, in the same cycle as `CHG`, when `D_OUT[i]` goes 0→1.
  - `FALL[i]` pulses the same way when `D_OUT[i]` goes 1→0.
  - Both reset to 0.
- `INCOND_EDGE_EN` undefined: the ports and their logic are absent. `D_OUT` and `CHG` behaviour is identical in both builds.

## Structure
- Package `incond_pkg` holds:
  - the state encoding `IDLE`=1'b0, `COUNT`=1'b1;
  - the default `DB` constant;
  - a function returning the counter width `max(1,$clog2(DB))`.
- Sub-module `debounce_bit`: one synchroniser, counter and FSM. It outputs its `D_OUT` bit and a flip flag.
- `fsm_in_cond` instantiates `debounce_bit` `W` times with a generate loop and registers `CHG` (and, with the macro, `RISE`/`FALL`) from the flip flags.

## Test plan
- Reset: hold `CLR`=0 for 3 cycles with `D_IN`=2'b11, then release → `D_OUT`=2'b00 and `CHG`=0 during reset and at release, no `CHG` pulse afterwards; `D_OUT`=2'b11 exactly 5 edges after the first post-release sample.
- Clean step: `D_IN` 00→01 at edge k → `D_OUT`=01 and `CHG`=1 after edge k+5, `CHG`=0 after edge k+6; the FSM downstream sees `A`=1.
- Bounce: `D_IN[1]` high for 3 cycles then low → `D_OUT[1]` stays 0 and `CHG` never asserts; repeat with a 4-cycle pulse → `D_OUT[1]` goes 1 for the pulse's length offset by 5.
- Simultaneous: `D_IN` 00→11 at one edge → both bits flip at the same edge with a single `CHG` cycle; `RISE`=2'b11 when `INCOND_EDGE_EN` is defined.
- Reset mid-count: change `D_IN` to 10, assert `CLR` after 2 cycles, release → counting restarts; `D_OUT`=10 exactly 5 edges after release.
- `DB`=1 build: step `D_IN` 00→10 at edge k → `D_OUT`=10 after edge k+2; a 1-cycle glitch propagates, and the bench confirms this as the specified behaviour.

Source files
------------

// File: rtl/incond_pkg.sv
`default_nettype none
// ============================================================================
// Module  : incond_pkg
// Purpose : Shared state encoding and sizing helpers for the input conditioner.
// Rev     : 1.0  initial release
// ============================================================================
package incond_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } incond_state_t;

    localparam int DB_DEFAULT = 4;

    // Debounce counter width, never narrower than one bit.
    function automatic int cnt_width(input int db);
        return (db > 2) ? $clog2(db) : 1;
    endfunction

endpackage : incond_pkg
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// Module  : debounce_bit
// Purpose : Two-flop synchroniser plus debounce counter/FSM for one input bit.
// Rev     : 1.0  initial release
// ============================================================================
module debounce_bit
    import incond_pkg::*;
#(
    parameter int   DB      = DB_DEFAULT,
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_d,
    output logic o_flip
);

    localparam int            c_CW   = cnt_width(DB);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DB - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    logic            r_s1;
    logic            r_s2;
    logic [c_CW-1:0] r_cnt;
    incond_state_t   r_state;
    logic            w_diff;

    assign w_diff = r_s2 ^ o_d;

    // Entering COUNT already accounts for the first disagreeing sample.
    assign o_flip = w_diff &&
                    ((DB == 1) || ((r_state == COUNT) && (r_cnt == c_LAST)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1    <= RST_BIT;
            r_s2    <= RST_BIT;
            o_d     <= RST_BIT;
            r_cnt   <= '0;
            r_state <= IDLE;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            if (o_flip) begin
                o_d <= r_s2;
            end
            case (r_state)
                IDLE: begin
                    if (w_diff && (DB != 1)) begin
                        r_state <= COUNT;
                        r_cnt   <= c_ONE;
                    end
                end
                COUNT: begin
                    if (!w_diff || (r_cnt == c_LAST)) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule : debounce_bit
`default_nettype wire

// File: rtl/fsm_in_cond.sv
`default_nettype none
// ============================================================================
// Module  : fsm_in_cond
// Purpose : Synchronise and debounce W raw inputs; publish levels and a change
//           strobe. Optional RISE/FALL strobes with INCOND_EDGE_EN.
// Rev     : 1.0  initial release
// ============================================================================
module fsm_in_cond
    import incond_pkg::*;
#(
    parameter int             W       = 2,
    parameter int             DB      = DB_DEFAULT,
    parameter logic [W-1:0]   RST_VAL = {W{1'b0}}
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic [W-1:0] D_IN,
    output logic [W-1:0] D_OUT,
    output logic         CHG
`ifdef INCOND_EDGE_EN
    ,
    output logic [W-1:0] RISE,
    output logic [W-1:0] FALL
`endif
);

    logic [W-1:0] w_flip;

    for (genvar i = 0; i < W; i++) begin : g_bit
        debounce_bit #(
            .DB      (DB),
            .RST_BIT (RST_VAL[i])
        ) u_bit (
            .clk    (CLK),
            .rst_n  (CLR),
            .i_d    (D_IN[i]),
            .o_d    (D_OUT[i]),
            .o_flip (w_flip[i])
        );
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            CHG <= 1'b0;
        end else begin
            CHG <= |w_flip;
        end
    end

`ifdef INCOND_EDGE_EN
    // A flipping bit takes the complement of its current level.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            RISE <= '0;
            FALL <= '0;
        end else begin
            RISE <= w_flip & ~D_OUT;
            FALL <= w_flip &  D_OUT;
        end
    end
`endif

endmodule : fsm_in_cond
`default_nettype wire

// File: tb/tb_fsm_in_cond.sv
`default_nettype none
// ============================================================================
// Module  : tb_fsm_in_cond
// Purpose : Self-checking bench for fsm_in_cond at DB=4 and DB=1.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fsm_in_cond;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] d_in = 2'b11;

    logic [1:0] dout4, dout1;
    logic       chg4, chg1;
`ifdef INCOND_EDGE_EN
    logic [1:0] rise4, fall4, rise1, fall1;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fsm_in_cond #(.W(2), .DB(4), .RST_VAL(2'b00)) dut4 (
        .CLK(clk), .CLR(clr), .D_IN(d_in), .D_OUT(dout4), .CHG(chg4)
`ifdef INCOND_EDGE_EN
        , .RISE(rise4), .FALL(fall4)
`endif
    );

    fsm_in_cond #(.W(2), .DB(1), .RST_VAL(2'b00)) dut1 (
        .CLK(clk), .CLR(clr), .D_IN(d_in), .D_OUT(dout1), .CHG(chg1)
`ifdef INCOND_EDGE_EN
        , .RISE(rise1), .FALL(fall1)
`endif
    );

    // Reference: a bit flips when its last DB synchronised samples all
    // disagree with the published level; hist[1] is the sample seen now.
    logic [1:0] m4_hist [0:4];
    logic [1:0] m4_out, m4_f, m4_rise, m4_fall;
    logic       m4_chg;
    logic [1:0] m1_hist [0:1];
    logic [1:0] m1_out, m1_f, m1_rise, m1_fall;
    logic       m1_chg;

    always_comb begin
        m4_f = 2'b11;
        m1_f = 2'b11;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++)
                if (m4_hist[1+j][i] == m4_out[i]) m4_f[i] = 1'b0;
            if (m1_hist[1][i] == m1_out[i]) m1_f[i] = 1'b0;
        end
    end

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int j = 0; j < 5; j++) m4_hist[j] <= 2'b00;
            for (int j = 0; j < 2; j++) m1_hist[j] <= 2'b00;
            m4_out <= 2'b00; m4_chg <= 1'b0; m4_rise <= 2'b00; m4_fall <= 2'b00;
            m1_out <= 2'b00; m1_chg <= 1'b0; m1_rise <= 2'b00; m1_fall <= 2'b00;
        end else begin
            m4_hist[0] <= d_in;
            for (int j = 1; j < 5; j++) m4_hist[j] <= m4_hist[j-1];
            m1_hist[0] <= d_in;
            m1_hist[1] <= m1_hist[0];
            m4_out  <= m4_out ^ m4_f;
            m4_chg  <= |m4_f;
            m4_rise <= m4_f & ~m4_out;
            m4_fall <= m4_f & m4_out;
            m1_out  <= m1_out ^ m1_f;
            m1_chg  <= |m1_f;
            m1_rise <= m1_f & ~m1_out;
            m1_fall <= m1_f & m1_out;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Continuous comparison against the reference, mid high phase.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            check("mon_dout4", 32'(dout4), 32'(m4_out));
            check("mon_chg4",  32'(chg4),  32'(m4_chg));
            check("mon_dout1", 32'(dout1), 32'(m1_out));
            check("mon_chg1",  32'(chg1),  32'(m1_chg));
`ifdef INCOND_EDGE_EN
            check("mon_rise4", 32'(rise4), 32'(m4_rise));
            check("mon_fall4", 32'(fall4), 32'(m4_fall));
            check("mon_rise1", 32'(rise1), 32'(m1_rise));
            check("mon_fall1", 32'(fall1), 32'(m1_fall));
`endif
        end
    end

    typedef struct {
        logic [1:0] d;
        int         n;
        logic [1:0] q;
        logic       c;
    } vec_t;

    vec_t vt [10];

    initial begin
        vt[0] = '{2'b00, 5, 2'b11, 1'b0};
        vt[1] = '{2'b00, 1, 2'b00, 1'b1};
        vt[2] = '{2'b00, 1, 2'b00, 1'b0};
        vt[3] = '{2'b01, 6, 2'b01, 1'b1};
        vt[4] = '{2'b01, 1, 2'b01, 1'b0};
        vt[5] = '{2'b11, 6, 2'b11, 1'b1};
        vt[6] = '{2'b11, 2, 2'b11, 1'b0};
        vt[7] = '{2'b10, 6, 2'b10, 1'b1};
        vt[8] = '{2'b00, 6, 2'b00, 1'b1};
        vt[9] = '{2'b00, 3, 2'b00, 1'b0};

        // Reset held with inputs high.
        for (int s = 0; s < 3; s++) begin
            step(1);
            check("rst_dout4", 32'(dout4), 32'h0);
            check("rst_chg4",  32'(chg4),  32'h0);
            check("rst_dout1", 32'(dout1), 32'h0);
        end
        clr = 1'b1;
        for (int s = 1; s <= 6; s++) begin
            step(1);
            check("rel_dout4", 32'(dout4), (s >= 6) ? 32'h3 : 32'h0);
            check("rel_chg4",  32'(chg4),  (s == 6) ? 32'h1 : 32'h0);
            check("rel_dout1", 32'(dout1), (s >= 3) ? 32'h3 : 32'h0);
            check("rel_chg1",  32'(chg1),  (s == 3) ? 32'h1 : 32'h0);
        end
        step(1);
        check("rel_chg4_off", 32'(chg4), 32'h0);

        // Table-driven steps on the DB=4 instance.
        for (int v = 0; v < 10; v++) begin
            d_in = vt[v].d;
            step(vt[v].n);
            check($sformatf("vec%0d_dout", v), 32'(dout4), 32'(vt[v].q));
            check($sformatf("vec%0d_chg", v),  32'(chg4),  32'(vt[v].c));
        end

        // Simultaneous rise and fall of both bits.
        d_in = 2'b11;
        step(5);
        check("sim_pre", 32'(dout4), 32'h0);
        step(1);
        check("sim_dout", 32'(dout4), 32'h3);
        check("sim_chg",  32'(chg4),  32'h1);
`ifdef INCOND_EDGE_EN
        check("sim_rise", 32'(rise4), 32'h3);
`endif
        step(1);
        check("sim_chg_off", 32'(chg4), 32'h0);
        d_in = 2'b00;
        step(6);
        check("sim_fall_dout", 32'(dout4), 32'h0);
`ifdef INCOND_EDGE_EN
        check("sim_fall", 32'(fall4), 32'h3);
`endif
        step(2);

        // Three-sample bounce is swallowed.
        d_in = 2'b10;
        step(3);
        d_in = 2'b00;
        for (int s = 0; s < 10; s++) begin
            step(1);
            check("bnc3_dout", 32'(dout4), 32'h0);
            check("bnc3_chg",  32'(chg4),  32'h0);
        end

        // Four-sample pulse passes, shifted by five edges.
        d_in = 2'b10;
        for (int s = 1; s <= 12; s++) begin
            step(1);
            if (s == 4) d_in = 2'b00;
            check("bnc4_dout", 32'(dout4), (s >= 6 && s <= 9) ? 32'h2 : 32'h0);
            check("bnc4_chg",  32'(chg4),  (s == 6 || s == 10) ? 32'h1 : 32'h0);
        end

        // Reset in the middle of a count.
        d_in = 2'b10;
        step(2);
        clr = 1'b0;
        step(1);
        check("mid_rst_dout", 32'(dout4), 32'h0);
        check("mid_rst_chg",  32'(chg4),  32'h0);
        clr = 1'b1;
        for (int s = 1; s <= 6; s++) begin
            step(1);
            check("mid_rel_dout", 32'(dout4), (s >= 6) ? 32'h2 : 32'h0);
        end

        // DB=1: two-edge latency and a one-cycle glitch propagates.
        d_in = 2'b00;
        step(7);
        d_in = 2'b10;
        step(2);
        check("db1_pre",  32'(dout1), 32'h0);
        step(1);
        check("db1_dout", 32'(dout1), 32'h2);
        check("db1_chg",  32'(chg1),  32'h1);
        d_in = 2'b00;
        step(7);
        d_in = 2'b01;
        for (int s = 1; s <= 6; s++) begin
            step(1);
            if (s == 1) d_in = 2'b00;
            check("glt_dout1", 32'(dout1), (s == 3) ? 32'h1 : 32'h0);
            check("glt_chg1",  32'(chg1),  (s == 3 || s == 4) ? 32'h1 : 32'h0);
            check("glt_dout4", 32'(dout4), 32'h0);
        end

        // Randomised traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            step(1);
            if ($urandom_range(0, 99) < 2) clr = 1'b0;
            else clr = 1'b1;
            if ($urandom_range(0, 5) == 0) d_in = 2'($urandom);
        end
        clr = 1'b1;
        step(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_fsm_in_cond
`default_nettype wire
